// File: rtl/axis_reg_pkg.sv
// Shared definitions for the AXI-Stream register slice: state encoding and default widths.
package axis_reg_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_PKT_CNT_W = 16;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_BUSY  = ST_BUSY,
        S_FULL  = ST_FULL
    } slice_state_e;

endpackage

// File: rtl/axis_pkt_stats.sv
// Beat and packet counters for any stream tap: driven by a handshake strobe and the last flag.
module axis_pkt_stats
    import axis_reg_pkg::*;
#(
    parameter int DataWidth     = DEF_DATA_W,
    parameter int PktCountWidth = DEF_PKT_CNT_W
) (
    input  logic                     counter_clk,
    input  logic                     reset,
    input  logic                     hs_i,
    input  logic                     last_i,
    output logic [DataWidth-1:0]     beat_count_o,
    output logic [PktCountWidth-1:0] pkt_count_o
);

    logic [DataWidth-1:0]     beat_q, beat_d;
    logic [PktCountWidth-1:0] pkt_q, pkt_d;

    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (hs_i) begin
            if (last_i) begin
                beat_d = '0;
                pkt_d  = pkt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge counter_clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            pkt_q  <= '0;
        end else begin
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
        end
    end

    assign beat_count_o = beat_q;
    assign pkt_count_o  = pkt_q;

endmodule

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer for AXI-Stream: every output, including s_ready, comes straight from a flop.
module axis_reg_slice
    import axis_reg_pkg::*;
#(
    parameter int DataWidth     = DEF_DATA_W,
    parameter int PktCountWidth = DEF_PKT_CNT_W
) (
    input  logic                     counter_clk,
    input  logic                     reset,
    input  logic [DataWidth-1:0]     s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [DataWidth-1:0]     m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [DataWidth-1:0]     beat_count,
    output logic [PktCountWidth-1:0] pkt_count
);

    slice_state_e         state_q, state_d;
    logic [DataWidth-1:0] main_data_q, main_data_d;
    logic                 main_last_q, main_last_d;
    logic [DataWidth-1:0] skid_data_q, skid_data_d;
    logic                 skid_last_q, skid_last_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic                 accept;
    logic                 consume;

    assign accept  = s_valid && s_ready_q;
    assign consume = m_valid_q && m_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_data_d = s_data;
                    main_last_d = s_last;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (accept && m_ready) begin
                    main_data_d = s_data;
                    main_last_d = s_last;
                end else if (accept) begin
                    skid_data_d = s_data;
                    skid_last_d = s_last;
                    state_d     = S_FULL;
                end else if (m_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (m_ready) begin
                    main_data_d = skid_data_q;
                    main_last_d = skid_last_q;
                    state_d     = S_BUSY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Handshake flags are decoded from the next state so they leave the block registered.
        s_ready_d = (state_d != S_FULL);
        m_valid_d = (state_d != S_EMPTY);
    end

    always_ff @(posedge counter_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_data_q;
    assign m_last  = main_last_q;

    axis_pkt_stats #(
        .DataWidth     (DataWidth),
        .PktCountWidth (PktCountWidth)
    ) u_stats (
        .counter_clk  (counter_clk),
        .reset        (reset),
        .hs_i         (consume),
        .last_i       (main_last_q),
        .beat_count_o (beat_count),
        .pkt_count_o  (pkt_count)
    );

endmodule

// File: tb/tb_axis_reg_slice.sv
// Scoreboard bench for axis_reg_slice; pkt_count is 4 bits wide so wrap-around is exercised.
module tb_axis_reg_slice;

    localparam int DW = 32;
    localparam int PW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [DW-1:0] beat_count;
    logic [PW-1:0] pkt_count;

    int checks = 0;
    int errors = 0;
    beat_t q[$];

    // model state owned by the monitor
    int            occ = 0;
    logic [DW-1:0] exp_beat = '0;
    logic [PW-1:0] exp_pkt = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          up_ff;
    logic          rnd_done;

    axis_reg_slice #(.DataWidth(DW), .PktCountWidth(PW)) dut (
        .counter_clk (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .beat_count  (beat_count),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // s_ready is only expected once a rising edge has seen reset released
    always @(posedge clk or negedge reset) begin
        if (!reset) up_ff <= 1'b0;
        else        up_ff <= 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the scoreboard and the occupancy/counter model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_beat", beat_count, 0);
            chk("rst_pkt", pkt_count, 0);
            q.delete();
            occ = 0;
            exp_beat = '0;
            exp_pkt = '0;
            prev_stall = 1'b0;
        end else begin
            chk("s_ready", s_ready, (up_ff && occ < 2) ? 1 : 0);
            chk("m_valid", m_valid, (occ > 0) ? 1 : 0);
            chk("beat_count", beat_count, exp_beat);
            chk("pkt_count", pkt_count, exp_pkt);
            if (prev_stall) begin
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", m_data);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.l);
                    if (e.l) begin
                        exp_beat = '0;
                        exp_pkt = exp_pkt + 1'b1;
                    end else begin
                        exp_beat = exp_beat + 1'b1;
                    end
                end
                occ--;
            end
            if (s_valid && s_ready) occ++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                q.push_back('{d: d, l: l});
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
                s_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_valid) && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // reset, then one 8-beat packet at full rate
        step(2);
        reset = 1'b1;
        #1;
        chk("sready_before_edge", s_ready, 0);
        step(1);
        chk("sready_after_edge", s_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(i, i == 7);
        drain();
        chk("t1_pkt", pkt_count, 1);
        chk("t1_beat", beat_count, 0);

        // backpressure mid-stream for three cycles
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h10 + i, i == 9);
            end
            begin
                step(3);
                m_ready = 1'b0;
                step(1);
                chk("bp_sready_low", s_ready, 0);
                chk("bp_mvalid", m_valid, 1);
                step(2);
                m_ready = 1'b1;
            end
        join
        drain();
        chk("t2_pkt", pkt_count, 2);
        chk("t2_beat", beat_count, 0);

        // random traffic: 200 packets of 5 beats
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    step($urandom_range(0, 1));
                    send(32'h1000 + i, (i % 5) == 4);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
            end
        join
        m_ready = 1'b1;
        drain();
        chk("t3_pkt_200_mod16", pkt_count, 200 % 16);
        chk("t3_beat", beat_count, 0);

        // 17 single-beat packets wrap the 4-bit packet counter
        do_reset();
        for (int i = 0; i < 17; i++) send(32'h500 + i, 1'b1);
        drain();
        chk("t4_pkt_wrap", pkt_count, 1);

        // fill both entries, then reset mid-cycle
        send(32'h200, 1'b0);
        drain();
        chk("t5_beat_pre", beat_count, 1);
        m_ready = 1'b0;
        send(32'h201, 1'b0);
        send(32'h202, 1'b0);
        chk("t5_full_sready", s_ready, 0);
        chk("t5_full_mvalid", m_valid, 1);
        chk("t5_full_mdata", m_data, 32'h201);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_mvalid", m_valid, 0);
        chk("t5_async_sready", s_ready, 0);
        chk("t5_async_beat", beat_count, 0);
        chk("t5_async_pkt", pkt_count, 0);
        step(2);
        reset = 1'b1;
        chk("t5_rel_sready0", s_ready, 0);
        step(1);
        chk("t5_rel_sready1", s_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h300 + i, i == 2);
        drain();
        chk("t5_pkt_after", pkt_count, 1);
        chk("t5_beat_after", beat_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_reg_slice.md
# axis_reg_slice

Full-throughput AXI-Stream register slice (two-entry skid buffer) that sits directly downstream of the counter stream source. It consumes the source's data/valid/last stream and re-drives it with every output registered, including the upstream ready. Combinational paths between producer and consumer are broken. Beat and packet statistics are kept for debug.

## Interface
Parameters:
- DataWidth, 32, width of the data path (s_data, m_data, beat_count).
- PktCountWidth, 16, width of the packet counter.

Ports:
- counter_clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- s_data  input  DataWidth  upstream data; connects to the source's count_up.
- s_valid  input  1  upstream valid.
- s_last  input  1  upstream end-of-packet marker.
- s_ready  output  1  upstream ready; driven straight from a flop.
- m_data  output  DataWidth  downstream data; registered.
- m_valid  output  1  downstream valid; registered.
- m_last  output  1  downstream last; registered.
- m_ready  input  1  downstream ready.
- beat_count  output  DataWidth  number of beats already transferred on m_* in the current packet.
- pkt_count  output  PktCountWidth  number of completed packets (m_last handshakes), modulo 2^PktCountWidth.

## Operation
- Storage: main register {data,last} drives m_*; skid register {data,last} holds one extra beat.
- State machine, three states:
  - EMPTY: main empty, skid empty.
  - BUSY: main full, skid empty.
  - FULL: main full, skid full.
- Transitions:
  - EMPTY, s_valid: load main; go to BUSY.
  - BUSY, s_valid and m_ready: load main from input; stay in BUSY.
  - BUSY, s_valid and not m_ready: load skid from input; go to FULL.
  - BUSY, m_ready and not s_valid: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, m_ready: main takes skid; go to BUSY.
  - FULL, not m_ready: hold.
- Handshake signals:
  - s_ready is 1 in EMPTY and BUSY and 0 in FULL. Its next value is computed from the next state, so it is registered.
  - m_valid is 1 in BUSY and FULL.
- Ordering and integrity:
  - Beats leave in arrival order.
  - No beat is dropped or duplicated.
  - Data and last travel together.
- A beat is accepted only on s_valid and s_ready. A beat is consumed only on m_valid and m_ready.
- While m_valid is 1 and m_ready is 0, m_data and m_last are held stable.
- beat_count:
  - Increments on every m handshake with m_last=0.
  - Clears to 0 on an m handshake with m_last=1.
  - Wraps modulo 2^DataWidth.
- pkt_count: increments on every m handshake with m_last=1 and wraps to 0 after its all-ones value.

## Timing
- Reset values (reset low): state EMPTY, s_ready 0, m_valid 0, m_data 0, m_last 0, skid contents 0, beat_count 0, pkt_count 0.
- s_ready rises on the first counter_clk edge after reset goes high.
- Latency: a beat accepted at edge N appears on m_* with m_valid=1 after edge N, i.e. one cycle.
- Throughput: one beat per cycle sustained while m_ready=1.
- Backpressure: after m_ready falls, one more beat can be absorbed into skid; s_ready is 0 from the following cycle.
- Simultaneous accept and consume in BUSY: no change in occupancy.
- Simultaneous events in FULL: s_valid is ignored because s_ready=0.
- Counters update on the same edge as the m handshake they count.
- Reset asserted mid-packet: all state is cleared asynchronously and in-flight beats are discarded.

## Structure
- Shared package axis_reg_pkg holds:
  - State encoding localparams: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - Default widths.
- Sub-module axis_pkt_stats implements beat_count and pkt_count. Its inputs are counter_clk, reset, a handshake strobe and last, so it is reusable on any stream tap.
- The state machine, main and skid registers stay in the top module.

## Test plan
- Reset, then source counting 0..7 with m_ready=1 throughout:
  - m_data is 0,1,...,7 on consecutive cycles, starting one cycle after the first accept.
  - m_last=1 only with data 7.
  - Afterwards pkt_count=1 and beat_count=0.
- Backpressure: m_ready=0 for 3 cycles in mid-stream with s_valid=1:
  - Exactly one extra beat is absorbed, then s_ready=0.
  - m_data holds its value.
  - Once m_ready=1, the sequence resumes with no gap or duplicate.
- Random m_ready (50%) and random s_valid over 1000 beats with packets of 5:
  - Output sequence equals input sequence.
  - pkt_count=200.
  - s_ready is never 1 while in FULL.
- pkt_count wrap with PktCountWidth=4: 17 one-beat packets leave pkt_count=1.
- Reset asserted low while in FULL:
  - Within the same cycle, m_valid=0, s_ready=0 and the counters read 0.
  - After release, s_ready=1 one edge later and the next packet passes intact.
